// File: rtl/dot_arbiter.sv
// dot_arbiter: round-robin arbiter that shares one freezable 3-stage,
// 3-lane fixed-point dot-product pipeline among NUM_REQ requesters.
// Each accepted op carries its requester id down a valid/id sideband.
// The whole pipeline freezes while a finished result waits on res_ready.
module dot_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int A_WIDTH     = 16,
    parameter int A_FRAC_BITS = 14,
    parameter int B_WIDTH     = 16,
    parameter int B_FRAC_BITS = 14,
    parameter int P_FRAC_BITS = 14,
    localparam int EXTRA      = A_FRAC_BITS + B_FRAC_BITS - P_FRAC_BITS,
    localparam int D_WIDTH    = A_WIDTH + B_WIDTH - EXTRA + 2,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][2:0][A_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ-1:0][2:0][B_WIDTH-1:0]  req_b,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [ID_W-1:0]                       res_id,
    output logic [D_WIDTH-1:0]                    res_d,
    output logic [1:0]                            in_flight
);
    localparam int P_W   = A_WIDTH + B_WIDTH;
    // Two guard bits: the sum of three full-range products cannot overflow.
    localparam int SUM_W = P_W + 2;

    logic                      stall;
    logic                      accept;
    logic [ID_W-1:0]           gnt_id;
    logic [ID_W-1:0]           ptr;
    logic                      vld1, vld2, vld3;
    logic [ID_W-1:0]           id1, id2, id3;
    logic signed [A_WIDTH-1:0] a1 [3];
    logic signed [B_WIDTH-1:0] b1 [3];
    logic signed [P_W-1:0]     p2 [3];
    logic signed [SUM_W-1:0]   sum3;
    logic [D_WIDTH-1:0]        d3;

    // A finished result that is not taken freezes every stage, empty ones included.
    assign stall = vld3 & ~res_ready;

    // Round-robin pick: first valid at or above ptr, else first valid below ptr.
    always_comb begin
        req_ready = '0;
        gnt_id    = '0;
        accept    = 1'b0;
        if (!stall) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!accept && req_valid[i] && (ID_W'(i) >= ptr)) begin
                    accept       = 1'b1;
                    gnt_id       = ID_W'(i);
                    req_ready[i] = 1'b1;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!accept && req_valid[i]) begin
                    accept       = 1'b1;
                    gnt_id       = ID_W'(i);
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Sideband valid/id shift register and round-robin pointer.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld1 <= 1'b0;
            vld2 <= 1'b0;
            vld3 <= 1'b0;
            id1  <= '0;
            id2  <= '0;
            id3  <= '0;
            ptr  <= '0;
        end else if (!stall) begin
            vld1 <= accept;
            if (accept) begin
                id1 <= gnt_id;
                // Explicit wrap so a non-power-of-two NUM_REQ never yields an unused id.
                ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            vld2 <= vld1;
            id2  <= id1;
            vld3 <= vld2;
            id3  <= id2;
        end
    end

    // Adder tree feeding stage 3.
    always_comb begin
        sum3 = SUM_W'(p2[0]) + SUM_W'(p2[1]) + SUM_W'(p2[2]);
    end

    // Datapath: register inputs, form products, then sum and rescale (floor).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < 3; k++) begin
                a1[k] <= '0;
                b1[k] <= '0;
                p2[k] <= '0;
            end
            d3 <= '0;
        end else if (!stall) begin
            for (int k = 0; k < 3; k++) begin
                if (accept) begin
                    a1[k] <= req_a[gnt_id][k];
                    b1[k] <= req_b[gnt_id][k];
                end
                p2[k] <= P_W'(a1[k]) * P_W'(b1[k]);
            end
            d3 <= D_WIDTH'(sum3 >>> EXTRA);
        end
    end

    assign res_valid = vld3;
    assign res_id    = id3;
    assign res_d     = d3;
    assign in_flight = 2'(vld1) + 2'(vld2) + 2'(vld3);

endmodule

// File: tb/tb_dot_arbiter.sv
// tb_dot_arbiter: table-driven single-op vectors plus hand-written
// sequences for fairness, backpressure, reset mid-flight and sparse traffic.
module tb_dot_arbiter;
    localparam int DW = 20;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic [2:0]            req_valid;
    logic [2:0]            req_ready;
    logic [2:0][2:0][15:0] req_a;
    logic [2:0][2:0][15:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [1:0]            res_id;
    logic [DW-1:0]         res_d;
    logic [1:0]            in_flight;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int r;
        int a0, a1, a2;
        int b0, b1, b2;
        int d;
    } vec_t;

    vec_t vecs [10];

    dot_arbiter dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_d     (res_d),
        .in_flight (in_flight)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [31:0] dx(input int d);
        logic [DW-1:0] t;
        t = d[DW-1:0];
        return 32'(t);
    endfunction

    task automatic set_req(input logic [1:0] r, input int a0, input int a1, input int a2,
                           input int b0, input int b1, input int b2);
        req_a[r][0] = 16'(a0);
        req_a[r][1] = 16'(a1);
        req_a[r][2] = 16'(a2);
        req_b[r][0] = 16'(b0);
        req_b[r][1] = 16'(b1);
        req_b[r][2] = 16'(b2);
    endtask

    // Wait (bounded) for the next result, check it, then consume it.
    task automatic expect_res(input string nm, input int id, input int d);
        int n;
        n = 0;
        @(negedge clk_in);
        while (!res_valid && n < 8) begin
            tick();
            @(negedge clk_in);
            n++;
        end
        chk({nm, "_valid"}, 32'(res_valid), 32'd1);
        chk({nm, "_id"}, 32'(res_id), 32'(id));
        chk({nm, "_d"}, 32'(res_d), dx(d));
        tick();
    endtask

    initial begin
        int lat;
        vecs[0] = '{1,  16384, 0, 0,   8192, 0, 0,   8192};
        vecs[1] = '{0,  -1, 0, 0,      1, 0, 0,      -1};
        vecs[2] = '{2,  -16384, -16384, -16384, 16384, 16384, 16384, -49152};
        vecs[3] = '{0,  16384, 16384, 16384, 16384, -16384, 8192, 8192};
        vecs[4] = '{1,  32767, 32767, 32767, 32767, 32767, 32767, 196596};
        vecs[5] = '{2,  -32768, -32768, -32768, -32768, -32768, -32768, 196608};
        vecs[6] = '{0,  -32768, -32768, -32768, 32767, 32767, 32767, -196602};
        vecs[7] = '{1,  1, 1, 1,       1, 1, 1,      0};
        vecs[8] = '{2,  100, 200, 300, 16384, 16384, 16384, 600};
        vecs[9] = '{0,  -1, -1, 0,     16383, 1, 0,  -1};

        rst_in    = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;

        // Reset state
        @(negedge clk_in);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_d", 32'(res_d), 32'd0);
        chk("rst_in_flight", 32'(in_flight), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        tick();

        // Fairness: all three valid for 9 cycles
        for (int i = 0; i < 3; i++) set_req(2'(i), 4096 * (i + 1), 0, 0, 16384, 0, 0);
        req_valid = 3'b111;
        for (int c = 0; c < 12; c++) begin
            if (c == 9) req_valid = '0;
            @(negedge clk_in);
            if (c < 9) chk("fair_grant", 32'(req_ready), 32'(1 << (c % 3)));
            if (c >= 3) begin
                chk("fair_res_valid", 32'(res_valid), 32'd1);
                chk("fair_res_id", 32'(res_id), 32'((c - 3) % 3));
                chk("fair_res_d", 32'(res_d), dx(4096 * (((c - 3) % 3) + 1)));
            end
            tick();
        end
        @(negedge clk_in);
        chk("fair_drained_valid", 32'(res_valid), 32'd0);
        chk("fair_drained_in_flight", 32'(in_flight), 32'd0);
        tick();

        // Backpressure: three ops, then res_ready low for 5 cycles
        set_req(2'd0, 16384, 0, 0, 16384, 0, 0);
        set_req(2'd1, -16384, 0, 0, 16384, 0, 0);
        set_req(2'd2, 4096, 0, 0, 16384, 0, 0);
        req_valid = 3'b111;
        @(negedge clk_in);
        chk("bp_grant0", 32'(req_ready), 32'b001);
        tick();
        req_valid = 3'b110;
        @(negedge clk_in);
        chk("bp_grant1", 32'(req_ready), 32'b010);
        tick();
        req_valid = 3'b100;
        @(negedge clk_in);
        chk("bp_grant2", 32'(req_ready), 32'b100);
        tick();
        res_ready = 1'b0;
        set_req(2'd0, 8192, 0, 0, 16384, 0, 0);
        req_valid = 3'b001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_in);
            chk("bp_hold_valid", 32'(res_valid), 32'd1);
            chk("bp_hold_id", 32'(res_id), 32'd0);
            chk("bp_hold_d", 32'(res_d), dx(16384));
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
            chk("bp_hold_in_flight", 32'(in_flight), 32'd3);
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk_in);
        chk("bp_rel_d0", 32'(res_d), dx(16384));
        chk("bp_rel_grant", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        @(negedge clk_in);
        chk("bp_rel_valid1", 32'(res_valid), 32'd1);
        chk("bp_rel_id1", 32'(res_id), 32'd1);
        chk("bp_rel_d1", 32'(res_d), dx(-16384));
        tick();
        @(negedge clk_in);
        chk("bp_rel_valid2", 32'(res_valid), 32'd1);
        chk("bp_rel_id2", 32'(res_id), 32'd2);
        chk("bp_rel_d2", 32'(res_d), dx(4096));
        tick();
        @(negedge clk_in);
        chk("bp_rel_valid3", 32'(res_valid), 32'd1);
        chk("bp_rel_id3", 32'(res_id), 32'd0);
        chk("bp_rel_d3", 32'(res_d), dx(8192));
        chk("bp_rel_in_flight", 32'(in_flight), 32'd1);
        tick();

        // Table-driven single ops: latency, id and value
        for (int v = 0; v < 10; v++) begin
            set_req(2'(vecs[v].r), vecs[v].a0, vecs[v].a1, vecs[v].a2,
                    vecs[v].b0, vecs[v].b1, vecs[v].b2);
            req_valid = '0;
            req_valid[2'(vecs[v].r)] = 1'b1;
            @(negedge clk_in);
            chk($sformatf("vec%0d_grant", v), 32'(req_ready), 32'(1 << vecs[v].r));
            tick();
            req_valid = '0;
            lat = 1;
            @(negedge clk_in);
            while (!res_valid && lat < 8) begin
                tick();
                @(negedge clk_in);
                lat++;
            end
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_id", v), 32'(res_id), 32'(vecs[v].r));
            chk($sformatf("vec%0d_d", v), 32'(res_d), dx(vecs[v].d));
            tick();
        end

        // Reset mid-flight with two ops in the pipe (ptr is 1 here)
        set_req(2'd0, 16384, 0, 0, 16384, 0, 0);
        set_req(2'd1, 16384, 0, 0, 16384, 0, 0);
        req_valid = 3'b011;
        @(negedge clk_in);
        chk("rstmid_grant1", 32'(req_ready), 32'b010);
        tick();
        req_valid = 3'b001;
        @(negedge clk_in);
        chk("rstmid_grant0", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        @(negedge clk_in);
        chk("rstmid_in_flight", 32'(in_flight), 32'd2);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            chk("rstmid_no_stale", 32'(res_valid), 32'd0);
            chk("rstmid_empty", 32'(in_flight), 32'd0);
            tick();
        end
        set_req(2'd0, 4096, 0, 0, 16384, 0, 0);
        set_req(2'd1, 8192, 0, 0, 16384, 0, 0);
        set_req(2'd2, 12288, 0, 0, 16384, 0, 0);
        req_valid = 3'b111;
        @(negedge clk_in);
        chk("rstmid_ptr0", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        expect_res("rstmid_next", 0, 4096);

        // Sparse traffic with pointer skip
        set_req(2'd2, 16384, 0, 0, 16384, 0, 0);
        set_req(2'd0, 4096, 0, 0, 16384, 0, 0);
        req_valid = 3'b100;
        @(negedge clk_in);
        chk("sparse_g2", 32'(req_ready), 32'b100);
        tick();
        req_valid = 3'b101;
        @(negedge clk_in);
        chk("sparse_g0", 32'(req_ready), 32'b001);
        tick();
        req_valid = 3'b100;
        @(negedge clk_in);
        chk("sparse_g2b", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        expect_res("sparse_r2", 2, 16384);
        expect_res("sparse_r0", 0, 4096);
        expect_res("sparse_r2b", 2, 16384);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
